imm_gen_pipe: RTL and testbench

//  Registered, XLEN-parametrised RISC-V immediate generator for the decode stage.

---
 rtl/imm_pkg.sv | 57 +++++
 rtl/imm_gen_pipe_if.sv | 34 +++
 rtl/imm_decode_comb.sv | 83 ++++++++
 rtl/imm_gen_pipe.sv | 104 ++++++++++
 tb/tb_imm_gen_pipe.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format enum, opcodes,
// and helpers that pull each RISC-V immediate out as a 32-bit signed value.
// Pure declarations; no ports, latency or backpressure of its own.
package imm_pkg;

    // Immediate format reported alongside every decoded instruction.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6
    } imm_fmt_e;

    // Major opcodes, inst[6:0].
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Each helper returns the immediate already sign-extended to 32 bits; the
    // decoder widens that to XLEN by replicating bit 31.
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // CSR unsigned immediate lives in the rs1 field; bit 31 is always 0 here,
    // so the common sign-extension path yields the required zero-extension.
    function automatic logic [31:0] imm_csr(input logic [31:0] inst);
        return {27'b0, inst[19:15]};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle for the immediate generator: instruction+tag in, imm+fmt+tag out.
// No logic; latency and backpressure are set by the module on the slave side.
// Modports: master = fetch/execute side (testbench), slave = imm_gen_pipe.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();

    // Upstream (fetch) side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [TAG_W-1:0]  in_tag;

    // Downstream (execute) side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    imm_fmt_e          out_fmt;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );

endinterface

// File: rtl/imm_decode_comb.sv
// Pure combinational RISC-V immediate decoder: inst -> XLEN immediate + format.
// Latency 0; no handshake. Optional macro IMM_ZICSR_UIMM_EN enables SYSTEM decode.
// Ports: inst_i (32b instruction), imm_o (XLEN, sign-extended), fmt_o (imm_fmt_e).
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o
);

    logic [6:0]  opc;
    logic [31:0] imm32;

    assign opc = inst_i[6:0];

    always_comb begin
        imm32 = '0;
        fmt_o = FMT_NONE;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                imm32 = imm_i(inst_i);
                fmt_o = FMT_I;
            end
            // The *W immediate forms only exist on RV64.
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    imm32 = imm_i(inst_i);
                    fmt_o = FMT_I;
                end
            end
            OPC_STORE: begin
                imm32 = imm_s(inst_i);
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = imm_b(inst_i);
                fmt_o = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = imm_u(inst_i);
                fmt_o = FMT_U;
            end
            OPC_JAL: begin
                imm32 = imm_j(inst_i);
                fmt_o = FMT_J;
            end
`ifdef IMM_ZICSR_UIMM_EN
            // funct3[2] selects the CSR*I forms that carry a 5-bit uimm.
            OPC_SYSTEM: begin
                if (inst_i[14]) begin
                    imm32 = imm_csr(inst_i);
                    fmt_o = FMT_CSR;
                end else begin
                    imm32 = imm_i(inst_i);
                    fmt_o = FMT_I;
                end
            end
`else
            OPC_SYSTEM: begin
                imm32 = '0;
                fmt_o = FMT_NONE;
            end
`endif
            default: begin
                imm32 = '0;
                fmt_o = FMT_NONE;
            end
        endcase
    end

    // Widen to XLEN by replicating bit 31 (U-type included, as RV64 requires).
    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_o = {{32{imm32[31]}}, imm32};
        end else begin : g_xlen32
            assign imm_o = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry (main + skid) output buffer.
// Latency 1 cycle accept->out_valid, 1 item/cycle; in_ready depends only on skid state.
// Backpressure: out_ready low parks one extra item in skid, then in_ready drops.
// Ports: clk, rst_n (sync, active low), flush, bus (imm_gen_pipe_if.slave).
// Optional macro IMM_ZICSR_UIMM_EN (decoded in imm_decode_comb) adds FMT_CSR.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, tag: '0};

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    entry_t          dec_ent;

    logic   main_vld_q, main_vld_d;
    entry_t main_q,     main_d;
    logic   skid_vld_q, skid_vld_d;
    entry_t skid_q,     skid_d;

    logic   accept;
    logic   pop;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_dec (
        .inst_i (bus.in_inst),
        .imm_o  (dec_imm),
        .fmt_o  (dec_fmt)
    );

    assign dec_ent = '{imm: dec_imm, fmt: dec_fmt, tag: bus.in_tag};

    // in_ready never looks at out_ready, so execute stalls cannot reach fetch
    // combinationally.
    assign bus.in_ready = rst_n & ~skid_vld_q;
    assign accept       = bus.in_valid & bus.in_ready;
    assign pop          = main_vld_q & bus.out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;

        if (flush) begin
            // Flush wins over both accept and pop; payloads are left stale.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            if (skid_vld_q) begin
                // accept cannot coincide here: skid full forces in_ready low.
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec_ent;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = dec_ent;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = dec_ent;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            main_q     <= ENTRY_RST;
            skid_vld_q <= 1'b0;
            skid_q     <= ENTRY_RST;
        end else begin
            main_vld_q <= main_vld_d;
            main_q     <= main_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.out_valid = main_vld_q;
    assign bus.out_imm   = main_q.imm;
    assign bus.out_fmt   = main_q.fmt;
    assign bus.out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an XLEN=32 and an XLEN=64 instance share identical stimulus.
// Expected entries are queued on accept; a negedge monitor pops and compares.
// Directed vectors with hand-computed immediates cover all formats and both XLENs.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    int          cur_idx;
    int          tag_ctr;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_inst   = in_inst;
    assign b32.in_tag    = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_inst   = in_inst;
    assign b64.in_tag    = in_tag;
    assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [2:0]  f32;
        logic [31:0] i32;
        logic [2:0]  f64;
        logic [63:0] i64;
    } vec_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } exp_t;

    localparam int NV = 13;
    vec_t vt [NV];
    exp_t q32 [$];
    exp_t q64 [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] inst,
                        input imm_fmt_e f32, input logic [31:0] i32,
                        input imm_fmt_e f64, input logic [63:0] i64);
        vt[i] = '{inst: inst, f32: f32, i32: i32, f64: f64, i64: i64};
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic held32 = 1'b0, held64 = 1'b0;
    exp_t last32, last64;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
            held32 = 1'b0;
            held64 = 1'b0;
        end else begin
            // stalled output must hold
            if (held32) begin
                chk("hold32_vld", 64'(b32.out_valid), 64'd1);
                chk("hold32_imm", 64'(b32.out_imm), last32.imm);
                chk("hold32_tag", 64'(b32.out_tag), 64'(last32.tag));
            end
            if (held64) begin
                chk("hold64_vld", 64'(b64.out_valid), 64'd1);
                chk("hold64_imm", b64.out_imm, last64.imm);
                chk("hold64_tag", 64'(b64.out_tag), 64'(last64.tag));
            end
            held32 = b32.out_valid && !b32.out_ready;
            held64 = b64.out_valid && !b64.out_ready;
            last32 = '{imm: 64'(b32.out_imm), fmt: b32.out_fmt, tag: b32.out_tag};
            last64 = '{imm: b64.out_imm, fmt: b64.out_fmt, tag: b64.out_tag};

            // pops
            if (b32.out_valid && b32.out_ready) begin
                chk("sb32_expected_item", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("out32_imm", 64'(b32.out_imm), e.imm);
                    chk("out32_fmt", 64'(b32.out_fmt), 64'(e.fmt));
                    chk("out32_tag", 64'(b32.out_tag), 64'(e.tag));
                end
            end
            if (b64.out_valid && b64.out_ready) begin
                chk("sb64_expected_item", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    chk("out64_imm", b64.out_imm, e.imm);
                    chk("out64_fmt", 64'(b64.out_fmt), 64'(e.fmt));
                    chk("out64_tag", 64'(b64.out_tag), 64'(e.tag));
                end
            end

            // accepts
            if (in_valid && b32.in_ready)
                q32.push_back('{imm: {32'b0, vt[cur_idx].i32}, fmt: vt[cur_idx].f32, tag: in_tag});
            if (in_valid && b64.in_ready)
                q64.push_back('{imm: vt[cur_idx].i64, fmt: vt[cur_idx].f64, tag: in_tag});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        in_valid = 1'b1;
        in_inst  = vt[idx].inst;
        in_tag   = 32'hC0DE_0000 + 32'(tag_ctr);
        tag_ctr++;
        cur_idx  = idx;
    endtask

    task automatic send(input int idx);
        bit got = 1'b0;
        drive(idx);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b32.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_accepted", 64'(got), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input string nm);
        repeat (3) step();
        @(negedge clk);
        chk(nm, 64'(q32.size() + q64.size()), 64'd0);
        chk({nm, "_idle"}, 64'(b32.out_valid | b64.out_valid), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //   idx inst           fmt32     imm32           fmt64     imm64
        setv(0,  32'hFFF00093, FMT_I,    32'hFFFFFFFF,   FMT_I,    64'hFFFFFFFF_FFFFFFFF); // addi -1
        setv(1,  32'hFE000EE3, FMT_B,    32'hFFFFFFFC,   FMT_B,    64'hFFFFFFFF_FFFFFFFC); // beq -4
        setv(2,  32'h800000B7, FMT_U,    32'h80000000,   FMT_U,    64'hFFFFFFFF_80000000); // lui
        setv(3,  32'hFE112C23, FMT_S,    32'hFFFFFFF8,   FMT_S,    64'hFFFFFFFF_FFFFFFF8); // sw -8
        setv(4,  32'hFFDFF0EF, FMT_J,    32'hFFFFFFFC,   FMT_J,    64'hFFFFFFFF_FFFFFFFC); // jal -4
        setv(5,  32'h00001517, FMT_U,    32'h00001000,   FMT_U,    64'h00000000_00001000); // auipc
        setv(6,  32'h7FF08067, FMT_I,    32'h000007FF,   FMT_I,    64'h00000000_000007FF); // jalr 2047
        setv(7,  32'hFFF0809B, FMT_NONE, 32'h00000000,   FMT_I,    64'hFFFFFFFF_FFFFFFFF); // addiw -1
        setv(8,  32'h0000001B, FMT_NONE, 32'h00000000,   FMT_I,    64'h00000000_00000000);
`ifdef IMM_ZICSR_UIMM_EN
        setv(9,  32'h300FD073, FMT_CSR,  32'h0000001F,   FMT_CSR,  64'h00000000_0000001F); // csrrwi
        setv(10, 32'h300110F3, FMT_I,    32'h00000300,   FMT_I,    64'h00000000_00000300); // csrrw
`else
        setv(9,  32'h300FD073, FMT_NONE, 32'h00000000,   FMT_NONE, 64'h0);
        setv(10, 32'h300110F3, FMT_NONE, 32'h00000000,   FMT_NONE, 64'h0);
`endif
        setv(11, 32'hFFFFFFFF, FMT_NONE, 32'h00000000,   FMT_NONE, 64'h0);                  // illegal opcode
        setv(12, 32'h0080006F, FMT_J,    32'h00000008,   FMT_J,    64'h00000000_00000008); // jal +8

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_tag = '0; cur_idx = 0; tag_ctr = 0;

        // reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_in_ready32", 64'(b32.in_ready), 64'd0);
        chk("rst_in_ready64", 64'(b64.in_ready), 64'd0);
        chk("rst_out_valid",  64'(b32.out_valid | b64.out_valid), 64'd0);
        chk("rst_out_imm64",  b64.out_imm, 64'd0);
        chk("rst_out_fmt",    64'(b32.out_fmt), 64'(FMT_NONE));
        chk("rst_out_tag",    64'(b32.out_tag), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(b32.in_ready & b64.in_ready), 64'd1);
        step();

        // single item, 1-cycle latency
        out_ready = 1'b1;
        send(0);
        @(negedge clk);
        chk("latency_out_valid", 64'(b32.out_valid & b64.out_valid), 64'd1);
        step();

        // back-to-back stream of every vector
        for (int i = 1; i < NV; i++) send(i);
        drain_check("stream_drained");

        // backpressure: two accepts fill main+skid, third waits
        out_ready = 1'b0;
        drive(0);
        @(negedge clk); chk("bp_rdy_1", 64'(b32.in_ready), 64'd1);
        step(); drive(1);
        @(negedge clk); chk("bp_rdy_2", 64'(b32.in_ready), 64'd1);
        step(); drive(2);
        @(negedge clk); chk("bp_rdy_full", 64'(b32.in_ready | b64.in_ready), 64'd0);
        step(); out_ready = 1'b1;
        @(negedge clk); chk("bp_out_0", 64'(b32.out_valid), 64'd1);
        chk("bp_rdy_still_full", 64'(b32.in_ready), 64'd0);
        step();
        @(negedge clk); chk("bp_out_1", 64'(b32.out_valid), 64'd1);
        chk("bp_rdy_freed", 64'(b32.in_ready), 64'd1);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("bp_out_2", 64'(b32.out_valid & b64.out_valid), 64'd1);
        step();
        drain_check("bp_drained");

        // flush with main+skid full and in_valid asserted
        out_ready = 1'b0;
        drive(3); step();
        drive(4); step();
        drive(5); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(b32.out_valid | b64.out_valid), 64'd0);
        chk("flush_in_ready",  64'(b32.in_ready & b64.in_ready), 64'd1);
        step();
        // flush in a cycle where the input would otherwise be accepted
        drive(6); step();
        drive(1); flush = 1'b1;
        @(negedge clk); chk("flush2_in_ready", 64'(b32.in_ready), 64'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("flush2_out_valid", 64'(b32.out_valid | b64.out_valid), 64'd0);
        step();
        out_ready = 1'b1;
        send(12);
        drain_check("flush_drained");

        // reset mid-stream with skid full
        out_ready = 1'b0;
        drive(0); step();
        drive(2); step();
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); chk("mid_rst_in_ready", 64'(b32.in_ready), 64'd0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(b32.out_valid | b64.out_valid), 64'd0);
        chk("mid_rst_out_imm32", 64'(b32.out_imm), 64'd0);
        chk("mid_rst_out_imm64", b64.out_imm, 64'd0);
        chk("mid_rst_in_ready",  64'(b32.in_ready & b64.in_ready), 64'd1);
        step();
        out_ready = 1'b1;
        send(8);
        send(7);
        drain_check("rst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
